mouse_init_sequencer: RTL

MOUSE_INIT_SEQUENCER -- requirements
Module: mouse_init_sequencer

---
 rtl/mouse_init_sequencer.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mouse_init_sequencer.sv
// PS/2 mouse bring-up sequencer: reset/ID handshake, enable streaming,
// then frame incoming 3-byte movement packets.
module mouse_init_sequencer #(
  parameter int unsigned TIMEOUT_CYC  = 25_000_000,
  parameter int unsigned BYTE_GAP_CYC = 100_000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       qzt_clk,
  input  logic       rst,
  input  logic       restart,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] status_pck_1,
  output logic [7:0] xm_pck_2,
  output logic [7:0] ym_pck_3,
  output logic       pkt_valid,
  output logic       init_done,
  output logic       init_error,
  output logic [3:0] state_dbg
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > BYTE_GAP_CYC) ? TIMEOUT_CYC : BYTE_GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 2);

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  typedef enum logic [3:0] {
    S_SEND_RST  = 4'd0,
    S_WAIT_ACK1 = 4'd1,
    S_WAIT_BAT  = 4'd2,
    S_WAIT_ID   = 4'd3,
    S_SEND_EN   = 4'd4,
    S_WAIT_ACK2 = 4'd5,
    S_B1        = 4'd6,
    S_B2        = 4'd7,
    S_B3        = 4'd8,
    S_FAIL      = 4'd15
  } state_e;

  state_e             state_q, state_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sent_q, sent_d;
  logic               tx_req_q, tx_req_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [7:0]         sh1_q, sh1_d;
  logic [7:0]         sh2_q, sh2_d;
  logic [7:0]         status_q, status_d;
  logic [7:0]         xm_q, xm_d;
  logic [7:0]         ym_q, ym_d;
  logic               pkt_valid_q, pkt_valid_d;
  logic               init_done_q, init_done_d;
  logic               init_error_q, init_error_d;
  logic               fail_c;
  logic               timeout_c;
  logic               gap_exp_c;
  logic               count_en_c;

  // Wait-limit comparisons on the shared idle counter
  always_comb begin
    timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    gap_exp_c = (cnt_q == CNT_W'(BYTE_GAP_CYC));
  end

  // Next-state, retry, packet framing and output computation
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    cnt_d        = cnt_q;
    sent_d       = sent_q;
    tx_req_d     = 1'b0;
    tx_data_d    = tx_data_q;
    sh1_d        = sh1_q;
    sh2_d        = sh2_q;
    status_d     = status_q;
    xm_d         = xm_q;
    ym_d         = ym_q;
    pkt_valid_d  = 1'b0;
    fail_c       = 1'b0;
    count_en_c   = 1'b0;

    if (restart) begin
      state_d = S_SEND_RST;
      retry_d = '0;
      sent_d  = 1'b0;
    end else begin
      case (state_q)
        S_SEND_RST: begin
          if (!sent_q) begin
            tx_req_d  = 1'b1;
            tx_data_d = CMD_RESET;
            sent_d    = 1'b1;
          end else if (tx_done) begin
            state_d = S_WAIT_ACK1;
            sent_d  = 1'b0;
          end
        end
        S_WAIT_ACK1: begin
          count_en_c = 1'b1;
          if (rx_valid) begin
            if (rx_data == RSP_ACK) state_d = S_WAIT_BAT;
            else                    fail_c  = 1'b1;
          end else if (timeout_c) begin
            fail_c = 1'b1;
          end
        end
        S_WAIT_BAT: begin
          count_en_c = 1'b1;
          if (rx_valid) begin
            if (rx_data == RSP_BAT) state_d = S_WAIT_ID;
            else                    fail_c  = 1'b1;
          end else if (timeout_c) begin
            fail_c = 1'b1;
          end
        end
        S_WAIT_ID: begin
          count_en_c = 1'b1;
          if (rx_valid) begin
            if (rx_data == RSP_ID) state_d = S_SEND_EN;
            else                   fail_c  = 1'b1;
          end else if (timeout_c) begin
            fail_c = 1'b1;
          end
        end
        S_SEND_EN: begin
          if (!sent_q) begin
            tx_req_d  = 1'b1;
            tx_data_d = CMD_ENABLE;
            sent_d    = 1'b1;
          end else if (tx_done) begin
            state_d = S_WAIT_ACK2;
            sent_d  = 1'b0;
          end
        end
        S_WAIT_ACK2: begin
          count_en_c = 1'b1;
          if (rx_valid) begin
            if (rx_data == RSP_ACK) state_d = S_B1;
            else                    fail_c  = 1'b1;
          end else if (timeout_c) begin
            fail_c = 1'b1;
          end
        end
        S_B1: begin
          // Bit 3 of the status byte is always set; use it to resync
          if (rx_valid && rx_data[3]) begin
            sh1_d   = rx_data;
            state_d = S_B2;
          end
        end
        S_B2: begin
          count_en_c = 1'b1;
          if (rx_valid) begin
            sh2_d   = rx_data;
            state_d = S_B3;
          end else if (gap_exp_c) begin
            state_d = S_B1;
          end
        end
        S_B3: begin
          count_en_c = 1'b1;
          if (rx_valid) begin
            status_d    = sh1_q;
            xm_d        = sh2_q;
            ym_d        = rx_data;
            pkt_valid_d = 1'b1;
            state_d     = S_B1;
          end else if (gap_exp_c) begin
            state_d = S_B1;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_SEND_RST;
          sent_d  = 1'b0;
        end
      endcase

      if (fail_c) begin
        sent_d = 1'b0;
        if (retry_q >= RTY_W'(MAX_RETRY)) begin
          state_d = S_FAIL;
        end else begin
          retry_d = retry_q + RTY_W'(1);
          state_d = S_SEND_RST;
        end
      end
    end

    if (restart || rx_valid || (state_d != state_q)) cnt_d = '0;
    else if (count_en_c)                             cnt_d = cnt_q + CNT_W'(1);

    init_done_d  = (state_d == S_B1) || (state_d == S_B2) || (state_d == S_B3);
    init_error_d = (state_d == S_FAIL);
  end

  // State and output registers
  always_ff @(posedge qzt_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_SEND_RST;
      retry_q      <= '0;
      cnt_q        <= '0;
      sent_q       <= 1'b0;
      tx_req_q     <= 1'b0;
      tx_data_q    <= CMD_RESET;
      sh1_q        <= 8'h00;
      sh2_q        <= 8'h00;
      status_q     <= 8'h00;
      xm_q         <= 8'h00;
      ym_q         <= 8'h00;
      pkt_valid_q  <= 1'b0;
      init_done_q  <= 1'b0;
      init_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      cnt_q        <= cnt_d;
      sent_q       <= sent_d;
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
      sh1_q        <= sh1_d;
      sh2_q        <= sh2_d;
      status_q     <= status_d;
      xm_q         <= xm_d;
      ym_q         <= ym_d;
      pkt_valid_q  <= pkt_valid_d;
      init_done_q  <= init_done_d;
      init_error_q <= init_error_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_req       = tx_req_q;
  assign status_pck_1 = status_q;
  assign xm_pck_2     = xm_q;
  assign ym_pck_3     = ym_q;
  assign pkt_valid    = pkt_valid_q;
  assign init_done    = init_done_q;
  assign init_error   = init_error_q;
  assign state_dbg    = state_q;

endmodule
